// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   PLL supervisor and staggered reset sequencer. Runs on the free-running
//   PLL reference clock, pulses the PLL RST pin, qualifies a synchronised
//   LOCK and then releases NUM_CH downstream resets one after another.
//   Timeouts re-reset the PLL; lock loss drops all channels and waits for
//   relock; force_relock restarts the PLL. Two saturating event counters
//   report lock losses and timeout retries to firmware.
//
// Ports
//   clk           free-running reference clock (PLL CLKI)
//   rst_n         synchronous active-low reset
//   pll_lock      PLL LOCK, asynchronous to clk
//   force_relock  single-cycle request to restart the PLL
//   cnt_clr       single-cycle clear of both event counters
//   pll_rst       PLL RST, active high
//   ch_rst_n      per-channel active-low resets, bit 0 released first
//   all_ready     all channels released and lock valid
//   state         FSM code (see table)
//   loss_count    lock-loss events, saturating
//   retry_count   lock-timeout PLL re-resets, saturating
//
// state | meaning
// ------+--------------------------------------------------------------
//   0   | RESET_PLL  pll_rst held high for PLL_RST_CYCLES
//   1   | WAIT_LOCK  waiting for lock_s, bounded by LOCK_TIMEOUT_CYCLES
//   2   | STABLE     lock_s must stay high for LOCK_STABLE_CYCLES
//   3   | SEQUENCE   releasing channels every STAGGER_CYCLES
//   4   | RUN        all channels released, monitoring lock
module pll_reset_sequencer #(
  parameter int NUM_CH              = 4,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int STAGGER_CYCLES      = 64,
  parameter int CNT_W               = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_lock,
  input  logic              force_relock,
  input  logic              cnt_clr,
  output logic              pll_rst,
  output logic [NUM_CH-1:0] ch_rst_n,
  output logic              all_ready,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  loss_count,
  output logic [CNT_W-1:0]  retry_count
);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    SEQUENCE  = 3'd3,
    RUN       = 3'd4
  } state_t;

  // One shared timer serves every state, so it is sized for the longest interval.
  localparam int T_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int T_B   = (LOCK_STABLE_CYCLES > STAGGER_CYCLES) ? LOCK_STABLE_CYCLES : STAGGER_CYCLES;
  localparam int T_MAX = (T_A > T_B) ? T_A : T_B;
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [TW-1:0] TC_RST    = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] TC_TMO    = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TC_STABLE = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TC_STAG   = TW'(STAGGER_CYCLES - 1);

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              lock_m, lock_s;
  logic              pll_rst_d, all_ready_d;
  logic [NUM_CH-1:0] ch_d;
  logic              loss_inc, retry_inc;
  logic [CNT_W-1:0]  loss_d, retry_d;

  assign state = state_q;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + TW'(1);
    pll_rst_d   = 1'b0;
    all_ready_d = 1'b0;
    ch_d        = ch_rst_n;
    loss_inc    = 1'b0;
    retry_inc   = 1'b0;

    // force_relock outranks lock loss in every state except RESET_PLL.
    if (state_q != RESET_PLL && force_relock) begin
      state_d   = RESET_PLL;
      timer_d   = '0;
      pll_rst_d = 1'b1;
      ch_d      = '0;
    end else begin
      case (state_q)
        RESET_PLL: begin
          pll_rst_d = 1'b1;
          ch_d      = '0;
          if (timer_q == TC_RST) begin
            state_d   = WAIT_LOCK;
            timer_d   = '0;
            pll_rst_d = 1'b0;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STABLE;
            timer_d = '0;
          end else if (timer_q == TC_TMO) begin
            state_d   = RESET_PLL;
            timer_d   = '0;
            pll_rst_d = 1'b1;
            retry_inc = 1'b1;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_d = WAIT_LOCK;
            timer_d = '0;
          end else if (timer_q == TC_STABLE) begin
            state_d = SEQUENCE;
            timer_d = '0;
          end
        end
        SEQUENCE: begin
          if (!lock_s) begin
            state_d  = WAIT_LOCK;
            timer_d  = '0;
            ch_d     = '0;
            loss_inc = 1'b1;
          end else if (&ch_rst_n) begin
            state_d     = RUN;
            timer_d     = '0;
            all_ready_d = 1'b1;
          end else if (timer_q == TC_STAG) begin
            // Shift a one in from bit 0 so channels release in index order.
            ch_d    = NUM_CH'({ch_rst_n, 1'b1});
            timer_d = '0;
          end
        end
        RUN: begin
          timer_d = timer_q;
          if (!lock_s) begin
            state_d  = WAIT_LOCK;
            timer_d  = '0;
            ch_d     = '0;
            loss_inc = 1'b1;
          end else begin
            all_ready_d = 1'b1;
          end
        end
        default: begin
          state_d   = RESET_PLL;
          timer_d   = '0;
          pll_rst_d = 1'b1;
          ch_d      = '0;
        end
      endcase
    end
  end

  // A clear coinciding with an event leaves that event counted.
  always_comb begin
    loss_d  = loss_count;
    retry_d = retry_count;
    if (cnt_clr) begin
      loss_d  = CNT_W'(loss_inc);
      retry_d = CNT_W'(retry_inc);
    end else begin
      if (loss_inc && (loss_count != '1))
        loss_d = loss_count + CNT_W'(1);
      if (retry_inc && (retry_count != '1))
        retry_d = retry_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_m      <= 1'b0;
      lock_s      <= 1'b0;
      state_q     <= RESET_PLL;
      timer_q     <= '0;
      pll_rst     <= 1'b1;
      ch_rst_n    <= '0;
      all_ready   <= 1'b0;
      loss_count  <= '0;
      retry_count <= '0;
    end else begin
      lock_m      <= pll_lock;
      lock_s      <= lock_m;
      state_q     <= state_d;
      timer_q     <= timer_d;
      pll_rst     <= pll_rst_d;
      ch_rst_n    <= ch_d;
      all_ready   <= all_ready_d;
      loss_count  <= loss_d;
      retry_count <= retry_d;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
module tb_pll_reset_sequencer;

  localparam int NUM_CH = 3;
  localparam int PR     = 4;
  localparam int TO     = 32;
  localparam int LS     = 8;
  localparam int ST     = 3;
  localparam int CW     = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pll_lock = 1'b0;
  logic              force_relock = 1'b0;
  logic              cnt_clr = 1'b0;
  logic              pll_rst;
  logic [NUM_CH-1:0] ch_rst_n;
  logic              all_ready;
  logic [2:0]        state;
  logic [CW-1:0]     loss_count;
  logic [CW-1:0]     retry_count;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .NUM_CH(NUM_CH), .PLL_RST_CYCLES(PR), .LOCK_TIMEOUT_CYCLES(TO),
    .LOCK_STABLE_CYCLES(LS), .STAGGER_CYCLES(ST), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .force_relock(force_relock),
    .cnt_clr(cnt_clr), .pll_rst(pll_rst), .ch_rst_n(ch_rst_n), .all_ready(all_ready),
    .state(state), .loss_count(loss_count), .retry_count(retry_count)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: phase code plus cycles spent in that phase; outputs are
  // derived arithmetically from (phase, age). Lock seen by the FSM is the
  // pll_lock value sampled two edges earlier.
  int m_phase, m_age, m_loss, m_retry;
  bit hist[$];

  function automatic logic [NUM_CH-1:0] m_ch();
    int n;
    if (m_phase == 4) return '1;
    if (m_phase != 3) return '0;
    n = m_age / ST;
    if (n > NUM_CH) n = NUM_CH;
    return NUM_CH'((1 << n) - 1);
  endfunction

  task automatic enter(input int p);
    m_phase = p;
    m_age   = 0;
  endtask

  task automatic model_step();
    bit ls, lost, retried;
    int sat;
    sat = (1 << CW) - 1;
    if (!rst_n) begin
      m_phase = 0; m_age = 0; m_loss = 0; m_retry = 0;
      hist.delete();
      return;
    end
    ls = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
    hist.push_back(pll_lock);
    if (hist.size() > 4) void'(hist.pop_front());
    lost = 0; retried = 0;
    if (m_phase != 0 && force_relock) enter(0);
    else begin
      case (m_phase)
        0: if (m_age + 1 == PR) enter(1); else m_age++;
        1: if (ls) enter(2);
           else if (m_age + 1 == TO) begin enter(0); retried = 1; end
           else m_age++;
        2: if (!ls) enter(1); else if (m_age + 1 == LS) enter(3); else m_age++;
        3: if (!ls) begin enter(1); lost = 1; end
           else if (m_age == ST * NUM_CH) enter(4);
           else m_age++;
        default: if (!ls) begin enter(1); lost = 1; end
      endcase
    end
    if (cnt_clr) begin
      m_loss  = lost ? 1 : 0;
      m_retry = retried ? 1 : 0;
    end else begin
      if (lost && m_loss < sat) m_loss++;
      if (retried && m_retry < sat) m_retry++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("state",     32'(state),       32'(m_phase));
    chk("pll_rst",   32'(pll_rst),     32'(m_phase == 0));
    chk("ch_rst_n",  32'(ch_rst_n),    32'(m_ch()));
    chk("all_ready", 32'(all_ready),   32'(m_phase == 4));
    chk("loss",      32'(loss_count),  32'(m_loss));
    chk("retry",     32'(retry_count), 32'(m_retry));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  initial begin
    m_phase = 0; m_age = 0; m_loss = 0; m_retry = 0;

    // Clean start with lock held high.
    rst_n = 1'b0; pll_lock = 1'b1;
    step();
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_pll_rst", 32'(pll_rst), 32'd1);
    rst_n = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      step();
      if (i == 3)  chk("clean_pll_rst_hi", 32'(pll_rst), 32'd1);
      if (i == 4)  chk("clean_pll_rst_lo", 32'(pll_rst), 32'd0);
      if (i == 5)  chk("clean_stable", 32'(state), 32'd2);
      if (i == 13) chk("clean_sequence", 32'(state), 32'd3);
      if (i == 16) chk("clean_ch001", 32'(ch_rst_n), 32'b001);
      if (i == 19) chk("clean_ch011", 32'(ch_rst_n), 32'b011);
      if (i == 22) chk("clean_ch111_notready", 32'({ch_rst_n, all_ready}), 32'b1110);
      if (i == 23) chk("clean_run", 32'({state, all_ready}), 32'b1001);
    end

    // Lock loss in RUN.
    pll_lock = 1'b0;
    repeat (3) step();
    chk("loss_state", 32'(state), 32'd1);
    chk("loss_ch", 32'({ch_rst_n, all_ready, pll_rst}), 32'd0);
    chk("loss_count1", 32'(loss_count), 32'd1);
    pll_lock = 1'b1;
    repeat (30) step();
    chk("relock_run", 32'(state), 32'd4);

    // Force relock coinciding with a lock loss.
    pll_lock = 1'b0;
    repeat (2) step();
    force_relock = 1'b1;
    step();
    force_relock = 1'b0;
    chk("force_state", 32'(state), 32'd0);
    chk("force_loss_kept", 32'(loss_count), 32'd1);
    pll_lock = 1'b1;
    repeat (3) step();
    chk("force_pll_rst_4", 32'(pll_rst), 32'd1);
    step();
    chk("force_pll_rst_end", 32'(pll_rst), 32'd0);
    repeat (35) step();
    chk("force_back_run", 32'(state), 32'd4);

    // Counter clear coinciding with a loss.
    pll_lock = 1'b0;
    repeat (2) step();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_with_loss", 32'(loss_count), 32'd1);
    pll_lock = 1'b1;

    // One-cycle glitch in STABLE restarts qualification.
    for (int i = 0; i < 50 && !(m_phase == 2 && m_age == 3); i++) step();
    chk("glitch_reach_stable", 32'(state), 32'd2);
    pll_lock = 1'b0;
    step();
    pll_lock = 1'b1;
    repeat (2) step();
    chk("glitch_wait", 32'(state), 32'd1);
    step();
    chk("glitch_restable", 32'(state), 32'd2);
    repeat (7) step();
    chk("glitch_full_qual", 32'(state), 32'd2);
    step();
    chk("glitch_sequence", 32'(state), 32'd3);
    chk("glitch_no_loss", 32'(loss_count), 32'd1);

    // Reset mid-SEQUENCE.
    for (int i = 0; i < 20 && m_ch() != 3'b001; i++) step();
    chk("midseq_ch001", 32'(ch_rst_n), 32'b001);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midseq_reset", 32'({state, pll_rst, ch_rst_n}), 32'({3'd0, 1'b1, 3'b000}));
    chk("midseq_counters", 32'({loss_count, retry_count}), 32'd0);

    // Lock timeout: retries every 36 cycles, saturating at 15.
    pll_lock = 1'b0;
    repeat (PR + TO) step();
    chk("timeout_retry1", 32'(retry_count), 32'd1);
    repeat (20 * (PR + TO)) step();
    chk("timeout_saturate", 32'(retry_count), 32'd15);
    chk("timeout_ch", 32'(ch_rst_n), 32'd0);

    // Randomized run against the model.
    pll_lock = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) pll_lock = ~pll_lock;
      force_relock = ($urandom_range(0, 199) == 0);
      cnt_clr      = ($urandom_range(0, 149) == 0);
      rst_n        = ($urandom_range(0, 499) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
